uart_rx_bfm: RTL and testbench
==============================

# uart_rx_bfm

Synthesizable UART receiver, the receiving end of the transmit BFM's serial `data` line. It deserializes 8N1 frames (idle high, start bit 0, LSB first, one stop bit 1) at a fixed clocks-per-bit rate. Received bytes go into a small FIFO that is read through a valid/ready handshake. It is used in benches as a loopback checker for the transmitter and as a standalone RX core in designs.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; must be at least 4.
- `DATA_BITS`, 8: data bits per frame.
- `FIFO_DEPTH`, 4: receive FIFO entries; must be a power of 2.

Ports (clock and reset first):
- `clk` in 1: single clock. All logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `data` in 1: serial input, asynchronous to `clk`, idle high.
- `rx_data` out DATA_BITS: FIFO head byte; valid only while `rx_valid` is 1.
- `rx_valid` out 1: FIFO is not empty.
- `rx_ready` in 1: consumer accepts the head byte. A pop occurs on any cycle with `rx_valid & rx_ready`.
- `frame_err` out 1: one-cycle pulse when a stop bit is sampled as 0.
- `overrun` out 1: one-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation
- `data` passes through a 2-flop synchronizer. Both flops reset to 1. Only the synchronized signal `rxs` is used.
- A bit counter `cnt` counts from 0 to CLKS_PER_BIT-1. A bit index `idx` counts from 0 to DATA_BITS-1.
- The FSM has five states:
  - IDLE: a falling edge on `rxs` (previous 1, current 0) moves to START with `cnt`=0.
  - START: when `cnt` = CLKS_PER_BIT/2 - 1, sample `rxs`. If 0, go to DATA with `cnt`=0 and `idx`=0. If 1, this is a false start: return to IDLE.
  - DATA: when `cnt` = CLKS_PER_BIT-1, shift `rxs` into bit `idx` (LSB first). After the last bit, go to STOP.
  - STOP: when `cnt` = CLKS_PER_BIT-1, sample `rxs`. If 1, push the byte and go to IDLE. If 0, pulse `frame_err`, discard the byte, and go to BREAK.
  - BREAK: wait for `rxs` = 1, then go to IDLE. This avoids false restarts during a break condition.
- Samples land at the mid-point of each bit. The FSM returns to IDLE at mid-stop-bit, so back-to-back frames with no idle gap are received.
- FIFO:
  - Push when full without a simultaneous pop: drop the byte and pulse `overrun`. FIFO contents are unchanged.
  - Push when full with a simultaneous pop: both happen, no `overrun`, count stays at FIFO_DEPTH.
  - Push and pop when not full: both happen, count unchanged.
  - Pointers wrap modulo FIFO_DEPTH. The count is kept with width log2(FIFO_DEPTH)+1.
- Reset:
  - State goes to IDLE and the FIFO is emptied.
  - Outputs: `rx_valid`=0, `rx_data`=0, `frame_err`=0, `overrun`=0.
  - A frame in progress is discarded. After reset, reception restarts only on a new falling edge.

## Timing
- Start edge on `data` to falling edge detected in IDLE: 3 cycles (2 synchronizer flops plus the edge register).
- Mid-stop sample to `rx_valid`=1 (from empty): the byte is registered on the sample edge, and `rx_valid`/`rx_data` are updated in the next cycle.
- `rx_data` is the registered FIFO head. After a pop it updates in the next cycle.
- `frame_err` and `overrun` are high for exactly 1 cycle, registered at the stop-sample cycle.
- A full frame is accepted in 9.5×CLKS_PER_BIT cycles after the start edge, plus the synchronizer delay. Sustained throughput is one byte per 10×CLKS_PER_BIT cycles.
- Tolerated baud mismatch: ±4% at CLKS_PER_BIT=16.

## Test plan
- Single frames 0xAA, 0x33, 0x3C from the transmit BFM, with `rx_ready`=1 -> each appears on `rx_data` with a 1-cycle `rx_valid`. No `frame_err` or `overrun`.
- Two back-to-back 0x3C frames with no idle gap, `rx_ready`=0 -> `rx_valid` stays high. Two pops return 0x3C, 0x3C, then `rx_valid`=0.
- A frame 0x55 with its stop bit forced to 0, then the line held low for 3 bit times -> one `frame_err` pulse, no FIFO push, no restart until the line goes high. A following frame 0x12 is received correctly.
- A glitch on `data`: low for CLKS_PER_BIT/4 cycles -> no data, no errors, FSM back in IDLE.
- Five frames 0x01–0x05 with `rx_ready`=0 and FIFO_DEPTH=4 -> `overrun` pulses once. Pops return 0x01–0x04. A 6th frame 0x06 is pushed on the same cycle as a pop while full -> no `overrun`, and 0x06 reads last.
- `rst` asserted for 1 cycle mid-DATA of frame 0x77, then a new frame 0x81 -> no 0x77 appears, 0x81 is received, and all outputs are 0 immediately after reset.

Source files
------------

// File: rtl/uart_rx_bfm.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, and a small
// receive FIFO drained through a valid/ready handshake.
module uart_rx_bfm #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = PW + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_e;

  state_e               state_q;
  logic                 sync1_q, rxs_q, prev_q;
  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 frame_err_q;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_q, rd_q, rd_d;
  logic [NW-1:0]        count_q, count_d;
  logic [DATA_BITS-1:0] rx_data_q, head_d;
  logic                 rx_valid_q, overrun_q;
  logic                 push, pop, full, wr_en;

  // Sync flops reset high so a reset never manufactures a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      rxs_q       <= 1'b1;
      prev_q      <= 1'b1;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= data;
      rxs_q       <= sync1_q;
      prev_q      <= rxs_q;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: if (prev_q && !rxs_q) begin
          state_q <= START;
          cnt_q   <= '0;
        end
        START: if (cnt_q == CW'(CLKS_PER_BIT/2 - 1)) begin
          cnt_q   <= '0;
          idx_q   <= '0;
          state_q <= rxs_q ? IDLE : DATA;
        end else cnt_q <= cnt_q + 1'b1;
        DATA: if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_q          <= '0;
          shift_q[idx_q] <= rxs_q;
          if (idx_q == IW'(DATA_BITS - 1)) state_q <= STOP;
          else                             idx_q   <= idx_q + 1'b1;
        end else cnt_q <= cnt_q + 1'b1;
        STOP: if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_q <= '0;
          if (rxs_q) state_q <= IDLE;
          else begin
            frame_err_q <= 1'b1;
            state_q     <= BRK;
          end
        end else cnt_q <= cnt_q + 1'b1;
        BRK: if (rxs_q) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign push  = (state_q == STOP) && (cnt_q == CW'(CLKS_PER_BIT - 1)) && rxs_q;
  assign pop   = rx_valid_q & rx_ready;
  assign full  = (count_q == NW'(FIFO_DEPTH));
  assign wr_en = push & (~full | pop);

  // Head is computed from next-state so rx_valid never lags the count.
  always_comb begin
    rd_d    = rd_q + PW'(pop);
    count_d = count_q + NW'(wr_en) - NW'(pop);
    head_d  = '0;
    if (count_d != '0) begin
      if (wr_en && (count_q == NW'(pop))) head_d = shift_q;
      else                                head_d = mem_q[rd_d];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= shift_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      rd_q       <= rd_d;
      count_q    <= count_d;
      rx_valid_q <= (count_d != '0);
      rx_data_q  <= head_d;
      overrun_q  <= push & full & ~pop;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx_bfm.sv
// Bench for uart_rx_bfm: directed frame table, multi-cycle corner sequences,
// and a randomized stream checked against a queue-based frame model.
module tb_uart_rx_bfm;
  localparam int CPB = 16;

  logic       clk = 1'b0, rst = 1'b1, data = 1'b1, rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun;

  always #5 clk = ~clk;

  uart_rx_bfm #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .data(data), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun)
  );

  int         n_cmp = 0, n_err = 0;
  int         fe_cnt = 0, ov_cnt = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  bit         done = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
    end
  end

  typedef struct {
    logic [7:0] val;
    logic       stop;
    int         hold_low;
    int         exp_fe;
    logic       exp_push;
  } vec_t;
  vec_t vt[5];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic pop_one(output logic [31:0] v);
    if (got_q.size() > 0) v = {24'h0, got_q.pop_front()};
    else v = '1;
  endtask

  // Leaves the line at the stop value; callers decide what follows.
  task automatic send(input logic [7:0] b, input logic stop);
    data = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      data = b[i];
      tick(CPB);
    end
    data = stop;
    tick(CPB);
  endtask

  task automatic chk_outs_zero(input string nm);
    chk({nm, ".rx_valid"}, 32'(rx_valid), 0);
    chk({nm, ".rx_data"}, {24'h0, rx_data}, 0);
    chk({nm, ".frame_err"}, 32'(frame_err), 0);
    chk({nm, ".overrun"}, 32'(overrun), 0);
  endtask

  initial begin
    int         fe0, ov0, gap;
    logic [31:0] v;
    logic [7:0] b;
    bit         bad, seen77;

    vt[0] = '{8'hAA, 1'b1, 0, 0, 1'b1};
    vt[1] = '{8'h33, 1'b1, 0, 0, 1'b1};
    vt[2] = '{8'h3C, 1'b1, 0, 0, 1'b1};
    vt[3] = '{8'h55, 1'b0, 3, 1, 1'b0};
    vt[4] = '{8'h12, 1'b1, 0, 0, 1'b1};

    tick(3);
    chk_outs_zero("reset");
    rst = 1'b0;
    tick(2 * CPB);

    rx_ready = 1'b1;
    foreach (vt[k]) begin
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      send(vt[k].val, vt[k].stop);
      if (vt[k].hold_low > 0) begin
        tick(vt[k].hold_low * CPB);
        chk("break_no_restart", 32'(got_q.size()), 0);
        chk("break_fe_once", 32'(fe_cnt - fe0), 32'(vt[k].exp_fe));
      end
      data = 1'b1;
      tick(2 * CPB);
      chk("vec_fe", 32'(fe_cnt - fe0), 32'(vt[k].exp_fe));
      chk("vec_ov", 32'(ov_cnt - ov0), 0);
      if (vt[k].exp_push) begin
        chk("vec_count", 32'(got_q.size()), 1);
        pop_one(v);
        chk("vec_data", v, {24'h0, vt[k].val});
      end else chk("vec_nopush", 32'(got_q.size()), 0);
    end

    // Glitch shorter than half a bit must be rejected as a false start.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    data = 1'b0;
    tick(CPB / 4);
    data = 1'b1;
    tick(2 * CPB);
    chk("glitch_nodata", 32'(got_q.size()), 0);
    chk("glitch_noerr", 32'(fe_cnt - fe0 + ov_cnt - ov0), 0);
    send(8'h5A, 1'b1);
    data = 1'b1;
    tick(2 * CPB);
    pop_one(v);
    chk("after_glitch", v, 32'h5A);

    // Back-to-back frames with the consumer stalled.
    rx_ready = 1'b0;
    send(8'h3C, 1'b1);
    send(8'h3C, 1'b1);
    data = 1'b1;
    tick(2 * CPB);
    chk("b2b_valid", 32'(rx_valid), 1);
    chk("b2b_head", {24'h0, rx_data}, 32'h3C);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    chk("b2b_valid_after1", 32'(rx_valid), 1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    chk("b2b_empty", 32'(rx_valid), 0);
    chk("b2b_count", 32'(got_q.size()), 2);
    pop_one(v); chk("b2b_pop0", v, 32'h3C);
    pop_one(v); chk("b2b_pop1", v, 32'h3C);

    // Overrun on the fifth frame, then push coincident with a pop while full.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
    data = 1'b1;
    tick(2 * CPB);
    chk("ovr_pulse", 32'(ov_cnt - ov0), 1);
    chk("ovr_head", {24'h0, rx_data}, 32'h01);
    fork
      send(8'h06, 1'b1);
      begin
        tick(3 + CPB / 2 + 9 * CPB - 1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
      end
    join
    data = 1'b1;
    tick(2 * CPB);
    chk("ovr_simul_pop", 32'(ov_cnt - ov0), 1);
    rx_ready = 1'b1;
    tick(8);
    rx_ready = 1'b0;
    chk("ovr_drained", 32'(rx_valid), 0);
    chk("ovr_count", 32'(got_q.size()), 5);
    foreach (exp_q[k]) exp_q.delete(k);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h06};
    foreach (exp_q[k]) begin
      pop_one(v);
      chk("ovr_order", v, {24'h0, exp_q[k]});
    end
    chk("ovr_fe", 32'(fe_cnt - fe0), 0);

    // Reset in the middle of a frame, while the line is high.
    rx_ready = 1'b1;
    fork
      send(8'h77, 1'b1);
      begin
        tick(40);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk_outs_zero("midrst");
      end
    join
    data = 1'b1;
    tick(8 * CPB);
    send(8'h81, 1'b1);
    data = 1'b1;
    tick(2 * CPB);
    seen77 = 1'b0;
    foreach (got_q[k]) if (got_q[k] == 8'h77) seen77 = 1'b1;
    chk("midrst_no77", 32'(seen77), 0);
    chk("midrst_last81", (got_q.size() > 0) ? {24'h0, got_q[$]} : '1, 32'h81);
    got_q.delete();

    // Randomized stream with random backpressure and occasional bad stop bits.
    exp_q.delete();
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          b   = 8'($urandom);
          bad = ($urandom_range(0, 5) == 0);
          send(b, !bad);
          if (!bad) exp_q.push_back(b);
          gap = bad ? 1 + $urandom_range(0, 1) : $urandom_range(0, 2);
          data = 1'b1;
          tick(gap * CPB);
        end
        data = 1'b1;
        tick(3 * CPB);
        done = 1'b1;
      end
      begin
        while (!done) begin
          rx_ready = 1'($urandom_range(0, 1));
          tick(1);
        end
      end
    join
    rx_ready = 1'b1;
    tick(10);
    rx_ready = 1'b0;
    chk("rnd_count", 32'(got_q.size()), 32'(exp_q.size()));
    foreach (exp_q[k]) begin
      pop_one(v);
      chk("rnd_data", v, {24'h0, exp_q[k]});
    end
    chk("rnd_fe", 32'(fe_cnt - fe0), 32'(40 - exp_q.size()));
    chk("rnd_ov", 32'(ov_cnt - ov0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
